// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-client memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_WIDTH = 28;
    localparam int MEM_WIDTH  = 128;

    typedef enum logic [1:0] {DRAIN, IDLE, BUSY, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
    typedef enum logic {OP_RD, OP_WR} op_e;

endpackage

// File: rtl/mem_arb_if.sv
// Client and memory-port bundle for mem_arbiter; slave = arbiter view, master = environment.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = MEM_WIDTH
) ();

    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational winner select between I and D requests.
// ARB_RR_EN: round-robin on ties; otherwise fixed D-over-I priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_e last_owner_i,
    output logic   gnt_vld_o,
    output owner_e gnt_owner_o
);

`ifndef ARB_RR_EN
    logic unused_last;
    assign unused_last = (last_owner_i == OWN_I);
`endif

    always_comb begin
        gnt_vld_o   = i_req_i | d_req_i;
        gnt_owner_o = OWN_D;
        if (i_req_i && d_req_i) begin
`ifdef ARB_RR_EN
            gnt_owner_o = (last_owner_i == OWN_D) ? OWN_I : OWN_D;
`else
            gnt_owner_o = OWN_D;
`endif
        end else if (i_req_i) begin
            gnt_owner_o = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (I/D cache) arbiter in front of a slow level-ready handshake memory.
// Tie policy selected by ARB_RR_EN inside mem_arb_grant.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    op_e                   op_q, op_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [MEM_WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [MEM_WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;

    logic   d_req;
    logic   gnt_vld;
    owner_e gnt_owner;

    // A D-cache asserting read and write together is treated as idle.
    assign d_req = bus.d_read ^ bus.d_write;

    mem_arb_grant u_grant (
        .i_req_i      (bus.i_read),
        .d_req_i      (d_req),
        .last_owner_i (owner_q),
        .gnt_vld_o    (gnt_vld),
        .gnt_owner_o  (gnt_owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DRAIN;
            owner_q     <= OWN_D;
            op_q        <= OP_RD;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        op_d        = op_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            // Memory ready is level-style; wait until it has really dropped.
            DRAIN: begin
                if (!bus.mem_ready) state_d = IDLE;
            end
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_owner;
                    state_d = BUSY;
                    if (gnt_owner == OWN_I) begin
                        op_d        = OP_RD;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = '0;
                    end else begin
                        op_d        = bus.d_write ? OP_WR : OP_RD;
                        mem_read_d  = bus.d_read;
                        mem_write_d = bus.d_write;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                    if (owner_q == OWN_I) begin
                        i_ready_d = 1'b1;
                        if (op_q == OP_RD) i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (op_q == OP_RD) d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = DRAIN;
            end
            default: state_d = DRAIN;
        endcase
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a slow level-ready memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if bus ();
    mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        op_e          op;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t         i_q[$];
    exp_t         d_q[$];
    owner_e       order_log[$];
    logic [127:0] mem[256];
    logic [127:0] ref_mem[256];
    int           checks = 0;
    int           fails = 0;
    int           rises = 0;
    int           d_pulses = 0;
    int           hold_force = -1;
    owner_e       model_last = OWN_D;

    function automatic logic [127:0] pat(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(a);
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slow memory: variable latency, ready held a few cycles after the request drops.
    initial begin
        int cnt, lat, hold;
        cnt = 0; lat = 1; hold = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.mem_ready) begin
                if (bus.mem_read || bus.mem_write) begin
                    if (cnt >= lat) begin
                        if (bus.mem_write) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
                        else bus.mem_rdata = mem[bus.mem_addr[7:0]];
                        bus.mem_ready = 1'b1;
                        hold = (hold_force >= 0) ? hold_force : int'($urandom_range(0, 3));
                        cnt = 0;
                        lat = int'($urandom_range(0, 3));
                    end else cnt++;
                end else cnt = 0;
            end else if (!(bus.mem_read || bus.mem_write)) begin
                if (hold == 0) bus.mem_ready = 1'b0;
                else hold--;
            end
        end
    end

    // Monitor: protocol checks plus scoreboard pop on each ready pulse.
    logic [159:0] prev_bus = '0;
    logic         prev_req = 1'b0, prev_ready = 1'b0, prev_ir = 1'b0, prev_dr = 1'b0;
    logic [27:0]  last_addr = '0;
    logic [127:0] last_wdata = '0;
    op_e          last_op = OP_RD;

    always @(negedge clk) begin
        logic req;
        exp_t e;
        if (!rst_n) begin
            prev_req = 1'b0; prev_ir = 1'b0; prev_dr = 1'b0;
        end else begin
            req = bus.mem_read | bus.mem_write;
            if (req && !prev_req) begin
                rises++;
                chk("req_after_drain", 160'(prev_ready), 160'(0));
                chk("rd_wr_excl", 160'(bus.mem_read & bus.mem_write), 160'(0));
                last_addr  = bus.mem_addr;
                last_wdata = bus.mem_wdata;
                last_op    = bus.mem_write ? OP_WR : OP_RD;
            end else if (req) begin
                chk("mem_hold", 160'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}), prev_bus);
            end
            if (bus.i_ready) begin
                chk("i_pulse_1cyc", 160'(prev_ir), 160'(0));
                chk("ready_excl", 160'(bus.d_ready), 160'(0));
                order_log.push_back(OWN_I);
                if (i_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL i_unexpected: got i_ready pulse, expected none");
                end else begin
                    e = i_q.pop_front();
                    chk("i_addr", 160'(last_addr), 160'(e.addr));
                    chk("i_op", 160'(last_op), 160'(e.op));
                    chk("i_rdata", 160'(bus.i_rdata), 160'(e.rdata));
                end
            end
            if (bus.d_ready) begin
                d_pulses++;
                chk("d_pulse_1cyc", 160'(prev_dr), 160'(0));
                order_log.push_back(OWN_D);
                if (d_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL d_unexpected: got d_ready pulse, expected none");
                end else begin
                    e = d_q.pop_front();
                    chk("d_addr", 160'(last_addr), 160'(e.addr));
                    chk("d_op", 160'(last_op), 160'(e.op));
                    if (e.op == OP_WR) chk("d_wdata", 160'(last_wdata), 160'(e.wdata));
                    else chk("d_rdata", 160'(bus.d_rdata), 160'(e.rdata));
                end
            end
            prev_bus = 160'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata});
            prev_req = req;
            prev_ir  = bus.i_ready;
            prev_dr  = bus.d_ready;
        end
        prev_ready = bus.mem_ready;
    end

    task automatic i_rd(input logic [27:0] a);
        exp_t e;
        bit got;
        @(posedge clk); #1;
        e.op = OP_RD; e.addr = a; e.wdata = '0; e.rdata = ref_mem[a[7:0]];
        i_q.push_back(e);
        bus.i_addr = a; bus.i_read = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = bus.i_ready;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL i_timeout: addr %h got no i_ready, expected one", a);
        end
        @(posedge clk); #1;
        bus.i_read = 1'b0;
        model_last = OWN_I;
    endtask

    task automatic d_op(input bit wr, input logic [27:0] a, input logic [127:0] wd);
        exp_t e;
        bit got;
        @(posedge clk); #1;
        e.op = wr ? OP_WR : OP_RD; e.addr = a; e.wdata = wr ? wd : '0;
        if (wr) ref_mem[a[7:0]] = wd;
        e.rdata = ref_mem[a[7:0]];
        d_q.push_back(e);
        bus.d_addr = a; bus.d_wdata = e.wdata; bus.d_read = !wr; bus.d_write = wr;
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = bus.d_ready;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL d_timeout: addr %h got no d_ready, expected one", a);
        end
        @(posedge clk); #1;
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        model_last = OWN_D;
    endtask

    task automatic wait_quiet();
        int q;
        q = 0;
        for (int n = 0; n < 200 && q < 3; n++) begin
            @(negedge clk);
            if (!bus.mem_ready && !bus.mem_read && !bus.mem_write) q++;
            else q = 0;
        end
    endtask

    initial begin
        int r0, dp0;
        owner_e first, second;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int a = 0; a < 256; a++) begin
            mem[a] = pat(a);
            ref_mem[a] = pat(a);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 160'({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready}), 160'(0));
        chk("rst_mem_addr", 160'(bus.mem_addr), 160'(0));
        chk("rst_mem_wdata", 160'(bus.mem_wdata), 160'(0));
        chk("rst_rdata", 160'({bus.i_rdata, bus.d_rdata}), 160'(0));
        rst_n = 1'b1;

        // 1: lone I read
        wait_quiet();
        r0 = rises; dp0 = d_pulses;
        i_rd(28'h10);
        wait_quiet();
        chk("t1_one_req", 160'(rises - r0), 160'(1));
        chk("t1_no_dready", 160'(d_pulses - dp0), 160'(0));
        chk("t1_i_rdata", 160'(bus.i_rdata), 160'(pat(16'h10)));

        // 2: write then read back
        d_op(1'b1, 28'h20, {16{8'hA5}});
        d_op(1'b0, 28'h20, '0);
        chk("t2_d_rdata", 160'(bus.d_rdata), 160'({16{8'hA5}}));

        // 3: two identical ties
        for (int t = 0; t < 2; t++) begin
            wait_quiet();
            order_log.delete();
`ifdef ARB_RR_EN
            first = (model_last == OWN_D) ? OWN_I : OWN_D;
`else
            first = OWN_D;
`endif
            second = (first == OWN_D) ? OWN_I : OWN_D;
            fork
                i_rd(28'(8'h11 + t));
                d_op(1'b0, 28'(8'h12 + t), '0);
            join
            chk("t3_tie_count", 160'(order_log.size()), 160'(2));
            if (order_log.size() == 2) begin
                chk("t3_tie_first", 160'(order_log[0]), 160'(first));
                chk("t3_tie_second", 160'(order_log[1]), 160'(second));
            end
            model_last = second;
        end

        // 4: back-to-back D reads with lingering ready
        wait_quiet();
        hold_force = 3;
        d_op(1'b0, 28'h30, '0);
        d_op(1'b0, 28'h31, '0);
        hold_force = -1;
        chk("t4_d_rdata", 160'(bus.d_rdata), 160'(pat(16'h31)));

        // 5: reset while BUSY with memory ready already high
        wait_quiet();
        hold_force = 4;
        @(posedge clk); #1;
        bus.i_addr = 28'h50; bus.i_read = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #2;
            if (bus.mem_ready && bus.mem_read) break;
        end
        rst_n = 1'b0;
        bus.i_read = 1'b0;
        #1;
        chk("t5_rst_ctrl", 160'({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready}), 160'(0));
        chk("t5_rst_addr", 160'(bus.mem_addr), 160'(0));
        chk("t5_rst_rdata", 160'({bus.i_rdata, bus.d_rdata}), 160'(0));
        model_last = OWN_D;
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_rd(28'h40);
        hold_force = -1;
        chk("t5_i_rdata", 160'(bus.i_rdata), 160'(pat(16'h40)));

        // 6: illegal D read+write alongside an I read
        wait_quiet();
        r0 = rises; dp0 = d_pulses;
        @(posedge clk); #1;
        bus.d_addr = 28'h70; bus.d_read = 1'b1; bus.d_write = 1'b1;
        i_rd(28'h60);
        repeat (10) @(posedge clk);
        chk("t6_one_req", 160'(rises - r0), 160'(1));
        chk("t6_no_dready", 160'(d_pulses - dp0), 160'(0));
        #1;
        bus.d_read = 1'b0; bus.d_write = 1'b0;

        // Random concurrent traffic: I reads low half, D owns the upper half.
        fork
            begin
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    i_rd(28'($urandom_range(0, 127)));
                end
            end
            begin
                repeat (30) begin
                    logic [27:0] a;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    a = 28'($urandom_range(128, 255));
                    if ($urandom_range(0, 1) == 1) d_op(1'b1, a, {$urandom, $urandom, $urandom, $urandom});
                    else d_op(1'b0, a, '0);
                end
            end
        join

        wait_quiet();
        chk("i_q_drained", 160'(i_q.size()), 160'(0));
        chk("d_q_drained", 160'(d_q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
